// File: rtl/rtc_inicializador.sv
// Power-up initialisation sequencer for the external RTC chip.
// After reset it walks once through a fixed table of register writes and holds
// each address/data pair on Direc/WR for HOLD_CYCLES clocks. auxiliar reports
// the current step, and reads NUM_STEPS once the table has been fully issued.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_LOAD  | first edge after reset release: present entry 0
//  S_WRITE | hold the current entry, advance once HOLD_CYCLES have elapsed
//  S_DONE  | table finished: outputs parked at 00/00/NUM_STEPS until reset
module rtc_inicializador #(
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_STEPS   = 6
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] Direc,
    output logic [7:0] WR,
    output logic [3:0] auxiliar
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'b00,
        S_WRITE = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] STEPS_DONE = 4'(NUM_STEPS);

    state_t     state, state_nx;
    logic [7:0] hold, hold_nx;
    logic [7:0] direc_nx, wr_nx;
    logic [3:0] aux_nx;
    logic [3:0] aux_inc;

    // RTC register address for each table step
    function automatic logic [7:0] tab_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    tab_addr = 8'h02;
            4'd1:    tab_addr = 8'h02;
            4'd2:    tab_addr = 8'h10;
            4'd3:    tab_addr = 8'h00;
            4'd4:    tab_addr = 8'h01;
            4'd5:    tab_addr = 8'h03;
            default: tab_addr = 8'h00;
        endcase
    endfunction

    // Data byte written at each table step (step 0 sets the init bit, step 1 clears it)
    function automatic logic [7:0] tab_data(input logic [3:0] idx);
        case (idx)
            4'd0:    tab_data = 8'h10;
            4'd2:    tab_data = 8'hD2;
            default: tab_data = 8'h00;
        endcase
    endfunction

    assign aux_inc = auxiliar + 4'd1;

    // Next state and next registered outputs
    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        direc_nx = Direc;
        wr_nx    = WR;
        aux_nx   = auxiliar;
        case (state)
            S_LOAD: begin
                direc_nx = tab_addr(4'd0);
                wr_nx    = tab_data(4'd0);
                aux_nx   = 4'd0;
                hold_nx  = 8'd0;
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                if (hold == HOLD_LAST) begin
                    hold_nx = 8'd0;
                    if (aux_inc < STEPS_DONE) begin
                        aux_nx   = aux_inc;
                        direc_nx = tab_addr(aux_inc);
                        wr_nx    = tab_data(aux_inc);
                    end else begin
                        aux_nx   = STEPS_DONE;
                        direc_nx = 8'h00;
                        wr_nx    = 8'h00;
                        state_nx = S_DONE;
                    end
                end else begin
                    hold_nx = hold + 8'd1;
                end
            end
            S_DONE: begin
                hold_nx  = 8'd0;
                direc_nx = 8'h00;
                wr_nx    = 8'h00;
                aux_nx   = STEPS_DONE;
            end
            default: begin
                // Unused encoding: park safely in the finished state
                hold_nx  = 8'd0;
                direc_nx = 8'h00;
                wr_nx    = 8'h00;
                aux_nx   = STEPS_DONE;
                state_nx = S_DONE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_LOAD;
            hold     <= 8'd0;
            Direc    <= 8'h00;
            WR       <= 8'h00;
            auxiliar <= 4'd0;
        end else begin
            state    <= state_nx;
            hold     <= hold_nx;
            Direc    <= direc_nx;
            WR       <= wr_nx;
            auxiliar <= aux_nx;
        end
    end

endmodule

// File: tb/tb_rtc_inicializador.sv
// Self-checking bench for rtc_inicializador: two instances (hold 4 and hold 1)
// compared every cycle against an edge-count model, plus literal spot checks
// and randomly timed asynchronous reset pulses.
module tb_rtc_inicializador;

    logic       clk;
    logic       rst4, rst1;
    logic [7:0] direc4, wr4, direc1, wr1;
    logic [3:0] aux4, aux1;

    int vectors;
    int miscompares;
    int e4, e1;      // rising edges seen with reset released, since last reset
    int cur;         // edge count used by the directed sequence

    logic [7:0] t_addr [6];
    logic [7:0] t_data [6];

    rtc_inicializador #(.HOLD_CYCLES(4), .NUM_STEPS(6)) u4 (
        .clk(clk), .reset(rst4), .Direc(direc4), .WR(wr4), .auxiliar(aux4));

    rtc_inicializador #(.HOLD_CYCLES(1), .NUM_STEPS(6)) u1 (
        .clk(clk), .reset(rst1), .Direc(direc1), .WR(wr1), .auxiliar(aux1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {Direc, WR, auxiliar} after e released edges with hold h
    function automatic logic [19:0] model(input int e, input int h);
        int k;
        if (e == 0) return 20'h0;
        k = (e - 1) / h;
        if (k >= 6) return {8'h00, 8'h00, 4'd6};
        return {t_addr[k], t_data[k], 4'(k)};
    endfunction

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h/%h/%0d expected %h/%h/%0d", nm, $time,
                     act[19:12], act[11:4], act[3:0], exp[19:12], exp[11:4], exp[3:0]);
        end
    endtask

    // Edge counters for the model
    always @(posedge clk or negedge rst4)
        if (!rst4) e4 <= 0; else if (e4 < 100000) e4 <= e4 + 1;

    always @(posedge clk or negedge rst1)
        if (!rst1) e1 <= 0; else if (e1 < 100000) e1 <= e1 + 1;

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("run_h4", {direc4, wr4, aux4}, model(e4, 4));
        chk("run_h1", {direc1, wr1, aux1}, model(e1, 1));
    end

    task automatic go(input int n);
        while (cur < n) begin
            @(posedge clk);
            cur++;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cur = 0;
        t_addr[0] = 8'h02; t_data[0] = 8'h10;
        t_addr[1] = 8'h02; t_data[1] = 8'h00;
        t_addr[2] = 8'h10; t_data[2] = 8'hD2;
        t_addr[3] = 8'h00; t_data[3] = 8'h00;
        t_addr[4] = 8'h01; t_data[4] = 8'h00;
        t_addr[5] = 8'h03; t_data[5] = 8'h00;

        // Model pinned by hand-computed values
        chk("model_e5_h4",  model(5, 4),  {8'h02, 8'h00, 4'd1});
        chk("model_e25_h4", model(25, 4), {8'h00, 8'h00, 4'd6});

        rst4 = 1'b0;
        rst1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_h4", {direc4, wr4, aux4}, 20'h0);
        chk("reset_h1", {direc1, wr1, aux1}, 20'h0);
        #1;
        rst4 = 1'b1;
        rst1 = 1'b1;

        go(1);
        chk("edge1_h4", {direc4, wr4, aux4}, {8'h02, 8'h10, 4'd0});
        chk("edge1_h1", {direc1, wr1, aux1}, {8'h02, 8'h10, 4'd0});
        go(4);
        chk("edge4_h4", {direc4, wr4, aux4}, {8'h02, 8'h10, 4'd0});
        go(5);
        chk("edge5_h4", {direc4, wr4, aux4}, {8'h02, 8'h00, 4'd1});
        go(6);
        chk("edge6_h1", {direc1, wr1, aux1}, {8'h03, 8'h00, 4'd5});
        go(7);
        chk("edge7_h1", {direc1, wr1, aux1}, {8'h00, 8'h00, 4'd6});
        go(9);
        chk("edge9_h4", {direc4, wr4, aux4}, {8'h10, 8'hD2, 4'd2});
        go(24);
        chk("edge24_h4", {direc4, wr4, aux4}, {8'h03, 8'h00, 4'd5});
        go(25);
        chk("edge25_h4", {direc4, wr4, aux4}, {8'h00, 8'h00, 4'd6});
        go(125);
        chk("done_h4", {direc4, wr4, aux4}, {8'h00, 8'h00, 4'd6});
        chk("done_h1", {direc1, wr1, aux1}, {8'h00, 8'h00, 4'd6});

        // Restart, then reset asynchronously during step 3 (edges 13..16)
        rst4 = 1'b0;
        #1;
        rst4 = 1'b1;
        cur = 0;
        go(14);
        chk("step3_h4", {direc4, wr4, aux4}, {8'h00, 8'h00, 4'd3});
        rst4 = 1'b0;
        #1;
        chk("async_clr_h4", {direc4, wr4, aux4}, 20'h0);
        #1;
        rst4 = 1'b1;
        cur = 0;
        go(1);
        chk("restart_h4", {direc4, wr4, aux4}, {8'h02, 8'h10, 4'd0});

        // Random reset pulses between edges on either instance
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
            #($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                rst4 = 1'b0;
                #1;
                chk("rand_clr_h4", {direc4, wr4, aux4}, 20'h0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                #1;
                rst4 = 1'b1;
            end else begin
                rst1 = 1'b0;
                #1;
                chk("rand_clr_h1", {direc1, wr1, aux1}, 20'h0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                #1;
                rst1 = 1'b1;
            end
        end
        repeat (30) @(negedge clk);
        #1;
        chk("final_h4", {direc4, wr4, aux4}, {8'h00, 8'h00, 4'd6});
        chk("final_h1", {direc1, wr1, aux1}, {8'h00, 8'h00, 4'd6});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
